// File: rtl/dmem_responder.sv
// Single-port word RAM data-memory target; valid/ready request and response channels, one request in flight.
// Latency: LATENCY cycles from accept edge to the first rsp_valid cycle. Backpressure: holds the response while rsp_ready is low, req_ready=0 until it is taken.
// Optional access-error checking is enabled with `define DMEM_RESPONDER_ERR_EN.
module dmem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
         $error("dmem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic             r_rsp_valid;
   logic [31:0]      r_rdata;
   logic [31:0]      r_mem [DEPTH_WORDS];

   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic             w_accept;
   logic [31:0]      w_load_dat;

   assign w_idx = req_addr[IDX_W+1:2];

`ifdef DMEM_RESPONDER_ERR_EN
   // Misaligned, or any index bit above the RAM depth set.
   assign w_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
`else
   logic w_unused_addr;
   assign w_err         = 1'b0;
   assign w_unused_addr = ^{req_addr[1:0], req_addr[ADDR_W-1:IDX_W+2]};
`endif

   assign req_ready  = (r_state == S_IDLE) && !rst;
   assign w_accept   = req_valid && req_ready;
   assign w_load_dat = (req_write || w_err) ? 32'h0 : r_mem[w_idx];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= (w_state_nxt == S_RESP);
         if (w_accept) begin
            r_rdata <= w_load_dat;
         end
      end
   end

`ifdef DMEM_RESPONDER_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_err;
      end
   end

   assign rsp_err = r_err;
`else
   assign rsp_err = 1'b0;
`endif

   // RAM is deliberately not reset; stores commit at the accept edge only.
   always_ff @(posedge clk) begin
      if (w_accept && req_write && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for the main scenarios, LATENCY=1 instance for streaming.
// Expectations follow DMEM_RESPONDER_ERR_EN when it is defined for the build.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid_l1, req_ready_l1, rsp_valid_l1, rsp_ready_l1, rsp_err_l1;
   logic [31:0] rsp_rdata_l1;
   logic [31:0] req_addr_l1, req_wdata_l1;
   logic [3:0]  req_be_l1;
   logic        req_write_l1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_l1), .req_ready(req_ready_l1), .req_write(req_write_l1),
      .req_addr(req_addr_l1), .req_wdata(req_wdata_l1), .req_be(req_be_l1),
      .rsp_valid(rsp_valid_l1), .rsp_ready(rsp_ready_l1),
      .rsp_rdata(rsp_rdata_l1), .rsp_err(rsp_err_l1)
   );

   // Presents a request until accepted, then returns the number of edges (accept edge included) until rsp_valid.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat);
      int guard;
      req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (!rsp_valid) begin
         tests++; fails++;
         $display("FAIL issue_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      end
   endtask

   task automatic take(output logic [31:0] rd, output logic er);
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
      req_valid_l1 = 0; req_write_l1 = 0; req_addr_l1 = 0; req_wdata_l1 = 0; req_be_l1 = 0;
      rsp_ready_l1 = 0;
      repeat (2) @(posedge clk); #1;
      tests++;
      if ({req_ready, rsp_valid, rsp_err} !== 3'b000) begin
         fails++; $display("FAIL reset_ctrl: ready/valid/err=%b required 000", {req_ready, rsp_valid, rsp_err});
      end
      tests++;
      if (rsp_rdata !== 32'h0) begin
         fails++; $display("FAIL reset_rdata: got %h required 00000000", rsp_rdata);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (req_ready !== 1'b1) begin
         fails++; $display("FAIL reset_release_ready: got %b required 1", req_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_load;
      int lat; logic [31:0] rd; logic er;
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL store_latency: got %0d required 2", lat); end
      take(rd, er);
      tests++;
      if ({er, rd} !== 33'h0) begin
         fails++; $display("FAIL store_rsp: err=%b rdata=%h required 0/00000000", er, rd);
      end
      tests++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         fails++; $display("FAIL store_after_take: valid/ready=%b required 01", {rsp_valid, req_ready});
      end
      issue(1'b0, 32'h10, 32'h0, 4'h0, lat);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL load_latency: got %0d required 2", lat); end
      take(rd, er);
      tests++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         fails++; $display("FAIL load_data: got %h err=%b required deadbeef err=0", rd, er);
      end
   endtask

   task automatic test_byte_enable;
      int lat; logic [31:0] rd; logic er;
      issue(1'b1, 32'h20, 32'h11223344, 4'hF, lat); take(rd, er);
      issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat); take(rd, er);
      issue(1'b0, 32'h20, 32'h0, 4'h0, lat); take(rd, er);
      tests++;
      if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL be_merge: got %h required 11bb33dd", rd); end
      issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL be_zero_latency: got %0d required 2", lat); end
      take(rd, er);
      issue(1'b0, 32'h20, 32'h0, 4'hF, lat); take(rd, er);
      tests++;
      if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL be_zero_noop: got %h required 11bb33dd", rd); end
   endtask

   task automatic test_backpressure;
      int lat;
      issue(1'b0, 32'h20, 32'h0, 4'h0, lat);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'h11BB33DD) begin
            fails++;
            $display("FAIL hold_cycle%0d: valid/ready=%b rdata=%h required 10 11bb33dd",
                     i, {rsp_valid, req_ready}, rsp_rdata);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      tests++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         fails++; $display("FAIL hold_release: valid/ready=%b required 01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_reset_mid;
      int lat; int seen; logic [31:0] rd; logic er;
      req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h5A5A5A5A; req_be = 4'hF; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_wait_ready: got %b required 0", req_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      tests++;
      if (seen !== 0) begin fails++; $display("FAIL mid_reset_dropped: rsp_valid seen %0d cycles required 0", seen); end
      issue(1'b0, 32'h4, 32'h0, 4'h0, lat); take(rd, er);
      tests++;
      if (rd !== 32'h5A5A5A5A) begin fails++; $display("FAIL mid_reset_commit: got %h required 5a5a5a5a", rd); end
   endtask

   task automatic test_err;
      int lat; logic [31:0] rd; logic er;
      logic [31:0] exp_rd3, exp_rd0;
      logic        exp_err;
`ifdef DMEM_RESPONDER_ERR_EN
      exp_rd3 = 32'h0;       exp_err = 1'b1; exp_rd0 = 32'h01020304;
`else
      exp_rd3 = 32'h01020304; exp_err = 1'b0; exp_rd0 = 32'hCAFEF00D;
`endif
      issue(1'b1, 32'h0, 32'h01020304, 4'hF, lat); take(rd, er);
      issue(1'b0, 32'h3, 32'h0, 4'h0, lat); take(rd, er);
      tests++;
      if (rd !== exp_rd3 || er !== exp_err) begin
         fails++; $display("FAIL err_misaligned: rdata=%h err=%b required %h/%b", rd, er, exp_rd3, exp_err);
      end
      issue(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, lat);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL err_latency: got %0d required 2", lat); end
      take(rd, er);
      tests++;
      if (rd !== 32'h0 || er !== exp_err) begin
         fails++; $display("FAIL err_oob_store: rdata=%h err=%b required 00000000/%b", rd, er, exp_err);
      end
      issue(1'b0, 32'h0, 32'h0, 4'h0, lat); take(rd, er);
      tests++;
      if (rd !== exp_rd0 || er !== 1'b0) begin
         fails++; $display("FAIL err_word0: rdata=%h err=%b required %h/0", rd, er, exp_rd0);
      end
   endtask

   task automatic test_back_to_back_l1;
      logic exp_v;
      req_write_l1 = 1'b0; req_addr_l1 = 32'h8; rsp_ready_l1 = 1'b1; req_valid_l1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         exp_v = (i % 2 == 0);
         tests++;
         if ({rsp_valid_l1, req_ready_l1} !== {exp_v, !exp_v}) begin
            fails++;
            $display("FAIL l1_stream_cycle%0d: valid/ready=%b required %b",
                     i, {rsp_valid_l1, req_ready_l1}, {exp_v, !exp_v});
         end
      end
      req_valid_l1 = 1'b0; rsp_ready_l1 = 1'b0;
   endtask

   initial begin
      test_reset;
      test_store_load;
      test_byte_enable;
      test_backpressure;
      test_reset_mid;
      test_err;
      test_back_to_back_l1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
